// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte stream to 32-bit little-endian instruction memory word writes.
// Optional trailing checksum byte enabled by INST_MEM_LOADER_CHECKSUM_EN.
package cotm32_pkg;
  localparam int INST_MEM_SIZE = 4096;
endpackage

module inst_mem_loader #(
  parameter int MEM_BYTES   = cotm32_pkg::INST_MEM_SIZE,
  parameter int WADDR_WIDTH = $clog2(MEM_BYTES / 4)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic                   o_rx_ready,
  output logic                   o_we,
  output logic [WADDR_WIDTH-1:0] o_waddr,
  output logic [31:0]            o_wdata,
  output logic                   o_busy,
  output logic                   o_cpu_hold,
  output logic                   o_done,
  output logic                   o_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    S_SUM  = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             lane_q, lane_d;
  logic [23:0]            buf_q, buf_d;
  logic [WADDR_WIDTH:0]   rem_q, rem_d;
  logic [WADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [7:0]             sum_q, sum_d;
`endif

  logic        rx_fire;
  logic [31:0] len_full;

  assign rx_fire  = i_rx_valid & o_rx_ready;
  // Length and data bytes share one shift register; the 4th byte completes the word.
  assign len_full = {i_rx_data, buf_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_LEN;
      S_LEN: begin
        if (rx_fire && lane_q == 2'd3) begin
          if (len_full == 32'd0) begin
            state_d = S_DONE;
          end else if (len_full > 32'(MEM_BYTES) || len_full[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // rem_q reaches zero on the last byte, so this is the cycle of the final write.
        if (rem_q == '0) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          state_d = S_SUM;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      S_SUM: if (rx_fire) state_d = ((sum_q + i_rx_data) == 8'h00) ? S_DONE : S_ERR;
`endif
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_rx_ready = 1'b0;
    case (state_q)
      S_LEN:  o_rx_ready = 1'b1;
      S_DATA: o_rx_ready = (rem_q != '0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      S_SUM:  o_rx_ready = 1'b1;
`endif
      default: o_rx_ready = 1'b0;
    endcase
    o_busy     = (state_q != S_IDLE);
    o_cpu_hold = (state_q != S_IDLE);
    o_done     = (state_q == S_DONE);
  end

  always_comb begin
    lane_d  = lane_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (state_q == S_IDLE && i_start) begin
      lane_d  = 2'd0;
      waddr_d = '0;
      err_d   = 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      sum_d   = 8'h00;
`endif
    end
    // Advance after each write except the last, so the address never wraps.
    if (we_q && rem_q != '0) waddr_d = waddr_q + 1'b1;
    if (rx_fire && (state_q == S_LEN || state_q == S_DATA)) begin
      lane_d = lane_q + 1'b1;
      buf_d  = {i_rx_data, buf_q[23:8]};
      if (state_q == S_DATA) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + i_rx_data;
`endif
        if (lane_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = len_full;
          rem_d   = rem_q - 1'b1;
        end
      end else if (lane_q == 2'd3) begin
        rem_d = len_full[WADDR_WIDTH+2:2];
      end
    end
    if (state_d == S_ERR) err_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_q  <= 2'd0;
      buf_q   <= 24'd0;
      rem_q   <= '0;
      waddr_q <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      sum_q   <= 8'h00;
`endif
    end else begin
      lane_q  <= lane_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign o_we    = we_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for inst_mem_loader with a 64-byte memory.
module tb_inst_mem_loader;
  localparam int MB = 64;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, we, busy, cpu_hold, done, err;
  logic [WW-1:0] waddr;
  logic [31:0]   wdata;

  inst_mem_loader #(.MEM_BYTES(MB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_we(we), .o_waddr(waddr), .o_wdata(wdata),
    .o_busy(busy), .o_cpu_hold(cpu_hold), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = word write, 1 = done pulse, 2 = error raised
  typedef struct packed {
    logic [1:0]    kind;
    logic [WW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic err_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an event, required none (scoreboard empty)", nm);
  endtask

  task automatic push(input logic [1:0] k, input int a, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.addr = WW'(a);
    e.data = d;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy !== cpu_hold) unexpected("busy_vs_hold");
    if (we) begin
      if (q.size() == 0) unexpected("write");
      else begin
        e = q.pop_front();
        chk("write", {2'd0, waddr, wdata}, {e.kind, e.addr, e.data});
      end
    end
    if (done) begin
      if (q.size() == 0) unexpected("done");
      else begin
        e = q.pop_front();
        chk("done_order", 64'(e.kind), 64'd1);
      end
    end
    if (err && !err_prev) begin
      if (q.size() == 0) unexpected("err");
      else begin
        e = q.pop_front();
        chk("err_order", 64'(e.kind), 64'd2);
      end
    end
    err_prev = err;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r;
    int n;
    r = 1'b0;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    do begin
      @(negedge clk);
      r = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 40);
    if (!r) unexpected("rx_ready_timeout");
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 0);
  endtask

  task automatic start_session();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  function automatic logic [7:0] wsum(input logic [31:0] w);
    return w[7:0] + w[15:8] + w[23:16] + w[31:24];
  endfunction

  logic [7:0]  img[MB];
  logic [31:0] w;
  logic [7:0]  s;

  initial begin
    #1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({rx_ready, we, busy, cpu_hold, done, err, waddr, wdata}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_outputs", 64'({rx_ready, we, busy, done, err}), 64'd0);

    // L=8 two-word image
    push(0, 0, 32'h00000013);
    push(0, 1, 32'h00100093);
    push(1, 0, 0);
    start_session();
    chk("hold_during_load", 64'(cpu_hold), 64'd1);
    send_word(32'd8);
    send_word(32'h00000013);
    send_word(32'h00100093);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send_byte(8'h4A, 0);
`endif
    wait_idle("end_L8");
    chk("hold_released", 64'(cpu_hold), 64'd0);
    chk("err_L8", 64'(err), 64'd0);
    chk("sb_empty_L8", 64'(q.size()), 64'd0);

    // L=0: done the cycle after the 4th length byte
    push(1, 0, 0);
    start_session();
    send_word(32'd0);
    chk("done_L0", 64'({done, busy}), 64'b11);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 64'({done, busy}), 64'b00);

    // L=6 (not word multiple)
    push(2, 0, 0);
    start_session();
    send_word(32'd6);
    wait_idle("end_L6");
    chk("err_L6", 64'({err, rx_ready}), 64'b10);

    // L=MEM+4 (too long); start must clear the sticky error
    start_session();
    chk("err_cleared_by_start", 64'(err), 64'd0);
    push(2, 0, 0);
    send_word(32'(MB + 4));
    wait_idle("end_Lbig");
    chk("err_Lbig", 64'({err, rx_ready}), 64'b10);
    chk("sb_empty_err", 64'(q.size()), 64'd0);

    // Full memory with random gaps and a stray i_start mid-load
    s = 8'h00;
    for (int i = 0; i < MB; i++) begin
      img[i] = 8'(i * 37 + 11);
      s      = s + img[i];
    end
    for (int i = 0; i < MB / 4; i++) push(0, i, {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
    push(1, 0, 0);
    start_session();
    send_word(32'(MB));
    for (int i = 0; i < MB; i++) begin
      if (i == 22) start = 1'b1;
      send_byte(img[i], int'($urandom_range(0, 5)));
      start = 1'b0;
    end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send_byte(8'(-s), 0);
`endif
    wait_idle("end_full");
    chk("err_full", 64'(err), 64'd0);
    chk("last_waddr", 64'(waddr), 64'(MB / 4 - 1));
    chk("sb_empty_full", 64'(q.size()), 64'd0);

    // Reset mid-word aborts the session
    push(0, 0, 32'hA1B2C3D4);
    start_session();
    send_word(32'd8);
    send_word(32'hA1B2C3D4);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", 64'({rx_ready, we, busy, cpu_hold, done, err, waddr, wdata}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_write_after_reset", 64'(q.size()), 64'd0);
    w = 32'hCAFEF00D;
    push(0, 0, w);
    push(1, 0, 0);
    start_session();
    send_word(32'd4);
    send_word(w);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    send_byte(8'(-wsum(w)), 0);
`endif
    wait_idle("end_fresh");
    chk("sb_empty_fresh", 64'(q.size()), 64'd0);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    // Bad checksum: words stay written, error raised, no done
    push(0, 0, 32'h00000013);
    push(0, 1, 32'h00100093);
    push(2, 0, 0);
    start_session();
    send_word(32'd8);
    send_word(32'h00000013);
    send_word(32'h00100093);
    send_byte(8'h4B, 0);
    wait_idle("end_badsum");
    chk("err_badsum", 64'(err), 64'd1);
    start_session();
    chk("err_cleared_badsum", 64'(err), 64'd0);
    push(1, 0, 0);
    send_word(32'd0);
    wait_idle("end_clear");
    chk("sb_empty_badsum", 64'(q.size()), 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
